// File: rtl/gun_position_tracker_if.sv
// Joystick/vblank inputs and gun position outputs exchanged between the
// hps_io joystick glue (master) and the gun position tracker (slave).
interface gun_position_tracker_if #(
  parameter int POS_W = 6
);
  logic             vblank;
  logic             joy_left;
  logic             joy_right;
  logic             joy_up;
  logic             joy_down;
  logic             recenter;
  logic [POS_W-1:0] gun_x;
  logic [POS_W-1:0] gun_y;
  logic             gun_moving;

  modport master (
    output vblank, joy_left, joy_right, joy_up, joy_down, recenter,
    input  gun_x, gun_y, gun_moving
  );

  modport slave (
    input  vblank, joy_left, joy_right, joy_up, joy_down, recenter,
    output gun_x, gun_y, gun_moving
  );
endinterface

// File: rtl/gun_position_tracker.sv
// Turns digital joystick directions into clamped absolute gun X/Y positions, stepped once per frame.
// Optional hold-to-accelerate is enabled by defining GUN_ACCEL_EN.
module gun_position_tracker #(
  parameter int POS_W       = 6,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 63,
  parameter int CENTER      = 32,
  parameter int STEP        = 1,
  parameter int STEP_MAX    = 4,
  parameter int ACCEL_DELAY = 8
) (
  input  logic                   clock_12,
  input  logic                   reset,
  gun_position_tracker_if.slave  gun_if
);

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_INC  = 2'd1,
    DIR_DEC  = 2'd2
  } dir_e;

  // Two guard bits keep underflow below zero and overflow above POS_MAX visible before clamping.
  localparam int EXT_W = POS_W + 2;
  localparam logic signed [EXT_W-1:0] MIN_S      = EXT_W'(POS_MIN);
  localparam logic signed [EXT_W-1:0] MAX_S      = EXT_W'(POS_MAX);
  localparam logic signed [EXT_W-1:0] STEP_S     = EXT_W'(STEP);
  localparam logic signed [EXT_W-1:0] STEP_MAX_S = EXT_W'(STEP_MAX);
  localparam logic [POS_W-1:0]        CENTER_P   = POS_W'(CENTER);

  logic             vblank_q;
  logic             tick;
  logic [POS_W-1:0] x_q, x_d;
  logic [POS_W-1:0] y_q, y_d;
  logic             moving_q, moving_d;
  dir_e             x_dir, y_dir;
  logic             x_accel, y_accel;

  function automatic dir_e axis_dir(logic inc, logic dec);
    if (inc && !dec) return DIR_INC;
    if (dec && !inc) return DIR_DEC;
    return DIR_NONE;
  endfunction

  function automatic logic [POS_W-1:0] axis_move(logic [POS_W-1:0] pos, dir_e dir, logic accel);
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] step;
    step = accel ? STEP_MAX_S : STEP_S;
    sum  = $signed({2'b00, pos});
    case (dir)
      DIR_INC: sum = sum + step;
      DIR_DEC: sum = sum - step;
      default: sum = sum;
    endcase
    if (sum < MIN_S) sum = MIN_S;
    if (sum > MAX_S) sum = MAX_S;
    return sum[POS_W-1:0];
  endfunction

  assign tick  = gun_if.vblank & ~vblank_q;
  assign x_dir = axis_dir(gun_if.joy_right, gun_if.joy_left);
  assign y_dir = axis_dir(gun_if.joy_down, gun_if.joy_up);

`ifdef GUN_ACCEL_EN
  localparam int              CNT_W   = $clog2(ACCEL_DELAY + 1);
  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(ACCEL_DELAY);

  logic [CNT_W-1:0] x_cnt_q, x_cnt_d, x_run;
  logic [CNT_W-1:0] y_cnt_q, y_cnt_d, y_run;
  dir_e             x_last_q, y_last_q;

  // A reversal or a release starts the run over, so the stored count only counts when the direction repeats.
  function automatic logic [CNT_W-1:0] run_so_far(dir_e dir, dir_e last, logic [CNT_W-1:0] cnt);
    return (dir != DIR_NONE && dir == last) ? cnt : '0;
  endfunction

  function automatic logic [CNT_W-1:0] run_next(dir_e dir, logic [CNT_W-1:0] run);
    if (dir == DIR_NONE) return '0;
    return (run == DELAY_C) ? run : run + 1'b1;
  endfunction

  always_comb begin
    x_run   = run_so_far(x_dir, x_last_q, x_cnt_q);
    y_run   = run_so_far(y_dir, y_last_q, y_cnt_q);
    x_accel = (x_run >= DELAY_C);
    y_accel = (y_run >= DELAY_C);
    x_cnt_d = run_next(x_dir, x_run);
    y_cnt_d = run_next(y_dir, y_run);
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      x_last_q <= DIR_NONE;
      y_last_q <= DIR_NONE;
    end else if (gun_if.recenter) begin
      x_cnt_q  <= '0;
      y_cnt_q  <= '0;
      x_last_q <= DIR_NONE;
      y_last_q <= DIR_NONE;
    end else if (tick) begin
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      x_last_q <= x_dir;
      y_last_q <= y_dir;
    end
  end
`else
  assign x_accel = 1'b0;
  assign y_accel = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns each _d signal; otherwise a latch is inferred.
    x_d      = x_q;
    y_d      = y_q;
    moving_d = moving_q;
    if (gun_if.recenter) begin
      x_d      = CENTER_P;
      y_d      = CENTER_P;
      moving_d = 1'b0;
    end else if (tick) begin
      x_d      = axis_move(x_q, x_dir, x_accel);
      y_d      = axis_move(y_q, y_dir, y_accel);
      moving_d = (x_d != x_q) || (y_d != y_q);
    end
  end

  // vblank_q resets high so a vblank already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      vblank_q <= 1'b1;
      x_q      <= CENTER_P;
      y_q      <= CENTER_P;
      moving_q <= 1'b0;
    end else begin
      // NOTE: non-blocking for all registered state so reads in other blocks see pre-edge values.
      vblank_q <= gun_if.vblank;
      x_q      <= x_d;
      y_q      <= y_d;
      moving_q <= moving_d;
    end
  end

  assign gun_if.gun_x      = x_q;
  assign gun_if.gun_y      = y_q;
  assign gun_if.gun_moving = moving_q;

endmodule

// File: tb/tb_gun_position_tracker.sv
// Self-checking bench for gun_position_tracker: directed scenarios plus random joystick/vblank traffic
// compared against a frame-level reference model; follows GUN_ACCEL_EN the same way as the design.
module tb_gun_position_tracker;

  localparam int CENTER      = 32;
  localparam int POS_MAX     = 63;
  localparam int STEP        = 1;
  localparam int STEP_MAX    = 4;
  localparam int ACCEL_DELAY = 8;
`ifdef GUN_ACCEL_EN
  localparam bit ACCEL_EN = 1'b1;
`else
  localparam bit ACCEL_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  gun_position_tracker_if #(.POS_W(6)) gun_if ();

  gun_position_tracker dut (
    .clock_12 (clk),
    .reset    (reset),
    .gun_if   (gun_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: positions as plain integers, run = consecutive ticks in the current direction.
  int m_x, m_y, m_run_x, m_run_y, m_last_x, m_last_y;
  bit m_moving, m_prev_vb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > POS_MAX) return POS_MAX;
    return v;
  endfunction

  function automatic int step_size(input int run);
    return (ACCEL_EN && run > ACCEL_DELAY) ? STEP_MAX : STEP;
  endfunction

  task automatic model_reset();
    m_x = CENTER; m_y = CENTER; m_moving = 1'b0; m_prev_vb = 1'b1;
    m_run_x = 0; m_run_y = 0; m_last_x = 0; m_last_y = 0;
  endtask

  task automatic model_edge(input bit vb, input bit l, input bit r, input bit u, input bit d, input bit rc);
    bit is_tick;
    int dx, dy, ox, oy;
    is_tick   = vb && !m_prev_vb;
    m_prev_vb = vb;
    if (rc) begin
      m_x = CENTER; m_y = CENTER; m_moving = 1'b0;
      m_run_x = 0; m_run_y = 0; m_last_x = 0; m_last_y = 0;
    end else if (is_tick) begin
      dx = int'(r) - int'(l);
      dy = int'(d) - int'(u);
      ox = m_x;
      oy = m_y;
      m_run_x  = (dx == 0) ? 0 : ((dx == m_last_x) ? m_run_x + 1 : 1);
      m_run_y  = (dy == 0) ? 0 : ((dy == m_last_y) ? m_run_y + 1 : 1);
      m_last_x = dx;
      m_last_y = dy;
      m_x = clamp(m_x + dx * step_size(m_run_x));
      m_y = clamp(m_y + dy * step_size(m_run_y));
      m_moving = (m_x != ox) || (m_y != oy);
    end
  endtask

  // Drive at the falling edge, let one rising edge happen, compare at the next falling edge.
  task automatic cycle(input bit vb, input bit l, input bit r, input bit u, input bit d, input bit rc);
    gun_if.vblank    = vb;
    gun_if.joy_left  = l;
    gun_if.joy_right = r;
    gun_if.joy_up    = u;
    gun_if.joy_down  = d;
    gun_if.recenter  = rc;
    @(posedge clk);
    model_edge(vb, l, r, u, d, rc);
    @(negedge clk);
    check("gun_x", gun_if.gun_x, m_x);
    check("gun_y", gun_if.gun_y, m_y);
    check("gun_moving", gun_if.gun_moving, m_moving);
  endtask

  task automatic tick_dir(input bit l, input bit r, input bit u, input bit d);
    cycle(1'b0, l, r, u, d, 1'b0);
    cycle(1'b1, l, r, u, d, 1'b0);
  endtask

  int         exp_y4[10];
  int         exp_y4_rev;
  int         exp_x3[5];
  bit         exp_m3[5];
  int         guard;
  logic [3:0] dirs;
  bit         vb_r, rc_r;

  initial begin
    gun_if.vblank    = 1'b1;
    gun_if.joy_left  = 1'b0;
    gun_if.joy_right = 1'b0;
    gun_if.joy_up    = 1'b0;
    gun_if.joy_down  = 1'b0;
    gun_if.recenter  = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    check("rst_x", gun_if.gun_x, 32);
    check("rst_y", gun_if.gun_y, 32);
    check("rst_moving", gun_if.gun_moving, 0);

    // Release with vblank already high: no tick may occur.
    reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rel_x", gun_if.gun_x, 32);
    check("rel_moving", gun_if.gun_moving, 0);

    // Hold right for three frames.
    for (int i = 0; i < 3; i++) begin
      tick_dir(1'b0, 1'b1, 1'b0, 1'b0);
      check("right_x", gun_if.gun_x, 33 + i);
      check("right_moving", gun_if.gun_moving, 1);
    end

    // Walk down to x=2 one step at a time, then push into the lower limit.
    guard = 0;
    while (m_x > 2 && guard < 100) begin
      tick_dir(1'b1, 1'b0, 1'b0, 1'b0);
      tick_dir(1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("walk_to_2", gun_if.gun_x, 2);
    exp_x3 = '{1, 0, 0, 0, 0};
    exp_m3 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick_dir(1'b1, 1'b0, 1'b0, 1'b0);
      check("left_clamp_x", gun_if.gun_x, exp_x3[i]);
      check("left_clamp_moving", gun_if.gun_moving, exp_m3[i]);
    end

    // Hold up for ten frames from centre, then reverse.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (ACCEL_EN) begin
      exp_y4     = '{31, 30, 29, 28, 27, 26, 25, 24, 20, 16};
      exp_y4_rev = 17;
    end else begin
      exp_y4     = '{31, 30, 29, 28, 27, 26, 25, 24, 23, 22};
      exp_y4_rev = 23;
    end
    for (int i = 0; i < 10; i++) begin
      tick_dir(1'b0, 1'b0, 1'b1, 1'b0);
      check("up_ramp_y", gun_if.gun_y, exp_y4[i]);
    end
    tick_dir(1'b0, 1'b0, 1'b0, 1'b1);
    check("down_reverse_y", gun_if.gun_y, exp_y4_rev);

    // Left+right together holds, then right resumes with the basic step.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick_dir(1'b1, 1'b1, 1'b0, 1'b0);
      check("both_x", gun_if.gun_x, 32);
      check("both_moving", gun_if.gun_moving, 0);
    end
    tick_dir(1'b0, 1'b1, 1'b0, 1'b0);
    check("after_both_x", gun_if.gun_x, 33);

    // Recenter on the same cycle as a tick at x=50 with right held.
    guard = 0;
    while (m_x < 50 && guard < 100) begin
      tick_dir(1'b0, 1'b1, 1'b0, 1'b0);
      tick_dir(1'b0, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("walk_to_50", gun_if.gun_x, 50);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("recenter_tick_x", gun_if.gun_x, 32);
    check("recenter_tick_moving", gun_if.gun_moving, 0);

    // Push into the upper limit.
    guard = 0;
    while (m_x < POS_MAX && guard < 80) begin
      tick_dir(1'b0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    for (int i = 0; i < 2; i++) begin
      tick_dir(1'b0, 1'b1, 1'b0, 1'b0);
      check("upper_clamp_x", gun_if.gun_x, 63);
      check("upper_clamp_moving", gun_if.gun_moving, 0);
    end

    // Reset mid-ramp must take effect without a clock edge.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick_dir(1'b0, 1'b1, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midreset_x", gun_if.gun_x, 32);
    check("midreset_y", gun_if.gun_y, 32);
    check("midreset_moving", gun_if.gun_moving, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) tick_dir(1'b0, 1'b1, 1'b0, 1'b1);

    // Random traffic: directions persist for a while so runs long enough to accelerate occur.
    dirs = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) dirs = 4'($urandom_range(0, 15));
      vb_r = ($urandom_range(0, 1) == 1);
      rc_r = ($urandom_range(0, 59) == 0);
      cycle(vb_r, dirs[0], dirs[1], dirs[2], dirs[3], rc_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
